// File: rtl/spi_slave_rx_core.sv
// SPI mode-0 slave shift core (MSB first, RX + TX); sticky overrun flag when SPI_SLAVE_OVERRUN_EN is defined.
// Latency: received word and valid flag appear one i_CLK after the completing SCK rise.
// No backpressure: a new word always overwrites o_RX_DATA, whether or not the previous one was acknowledged.
module spi_slave_rx_core #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [1:0]            i_SCK_Q,
    input  logic [1:0]            i_CS_Q,
    input  logic                  i_MOSI,
    input  logic [DATA_WIDTH-1:0] i_TX_DATA,
    input  logic                  i_RX_ACK,
    output logic [DATA_WIDTH-1:0] o_RX_DATA,
    output logic                  o_RX_VALID,
    output logic                  o_MISO,
    output logic                  o_BUSY,
    output logic                  o_OVERRUN
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    // The final bit is taken straight from i_MOSI, so only DATA_WIDTH-1 bits are held here.
    logic [DATA_WIDTH-2:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  reload_q, reload_d;

    logic                  sck_rise, sck_fall;
    logic                  cs_rise, cs_fall;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] rx_shifted;

    assign sck_rise   = (i_SCK_Q == 2'b01);
    assign sck_fall   = (i_SCK_Q == 2'b10);
    assign cs_fall    = (i_CS_Q == 2'b10);
    assign cs_rise    = (i_CS_Q == 2'b01);
    assign rx_shifted = {rx_sr_q, i_MOSI};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        reload_d   = reload_q;
        word_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    tx_sr_d   = i_TX_DATA;
                    reload_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    tx_sr_d   = '0;
                    reload_d  = 1'b0;
                end else if (!cs_fall) begin
                    // Any CS edge in the same cycle masks the SCK edge.
                    if (sck_rise) begin
                        rx_sr_d = rx_shifted[DATA_WIDTH-2:0];
                        if (bit_cnt_q == LAST_BIT) begin
                            word_done = 1'b1;
                            bit_cnt_d = '0;
                            reload_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (sck_fall) begin
                        if (reload_q) begin
                            tx_sr_d  = i_TX_DATA;
                            reload_d = 1'b0;
                        end else begin
                            tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        if (word_done) begin
            rx_data_d  = rx_shifted;
            rx_valid_d = 1'b1;
        end else if (i_RX_ACK) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            reload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            reload_q   <= reload_d;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (word_done && rx_valid_q && !i_RX_ACK) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign o_OVERRUN = overrun_q;
`else
    assign o_OVERRUN = 1'b0;
`endif

    assign o_RX_DATA  = rx_data_q;
    assign o_RX_VALID = rx_valid_q;
    assign o_BUSY     = (state_q == ST_SHIFT);
    assign o_MISO     = (state_q == ST_SHIFT) && tx_sr_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_rx_core.sv
// Directed bench for spi_slave_rx_core (DATA_WIDTH=16): SCK/CS histories driven at the negedge, outputs sampled 1ns after posedge.
module tb_spi_slave_rx_core;

    logic        i_CLK;
    logic        i_RST;
    logic [1:0]  i_SCK_Q;
    logic [1:0]  i_CS_Q;
    logic        i_MOSI;
    logic [15:0] i_TX_DATA;
    logic        i_RX_ACK;
    logic [15:0] o_RX_DATA;
    logic        o_RX_VALID;
    logic        o_MISO;
    logic        o_BUSY;
    logic        o_OVERRUN;

    int checks = 0;
    int errors = 0;

`ifdef SPI_SLAVE_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    spi_slave_rx_core #(.DATA_WIDTH(16)) dut (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_SCK_Q    (i_SCK_Q),
        .i_CS_Q     (i_CS_Q),
        .i_MOSI     (i_MOSI),
        .i_TX_DATA  (i_TX_DATA),
        .i_RX_ACK   (i_RX_ACK),
        .o_RX_DATA  (o_RX_DATA),
        .o_RX_VALID (o_RX_VALID),
        .o_MISO     (o_MISO),
        .o_BUSY     (o_BUSY),
        .o_OVERRUN  (o_OVERRUN)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic step(input logic [1:0] sck, input logic [1:0] cs, input logic mosi, input logic ack);
        @(negedge i_CLK);
        i_SCK_Q  = sck;
        i_CS_Q   = cs;
        i_MOSI   = mosi;
        i_RX_ACK = ack;
        @(posedge i_CLK);
        #1;
    endtask

    task automatic cs_fall();
        step(2'b00, 2'b10, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic cs_rise();
        step(2'b00, 2'b01, 1'b0, 1'b0);
        step(2'b00, 2'b11, 1'b0, 1'b0);
    endtask

    // Shifts n bits of w MSB first; when n==16 checks valid just before and right after the completing rise.
    task automatic send_bits(input logic [15:0] w, input int n, input logic pre_valid,
                             input logic ack_last, output logic [15:0] miso_w);
        miso_w = '0;
        for (int i = 0; i < n; i++) begin
            miso_w[15-i] = o_MISO;
            if (i == 15) begin
                checks++;
                if (o_RX_VALID !== pre_valid) begin
                    errors++;
                    $display("FAIL valid_before_last_rise: got %b expected %b", o_RX_VALID, pre_valid);
                end
            end
            step(2'b01, 2'b00, w[15-i], (i == n - 1) && ack_last);
            if (i == 15) begin
                checks++;
                if (o_RX_VALID !== 1'b1 || o_RX_DATA !== w) begin
                    errors++;
                    $display("FAIL completion: got valid=%b data=%h expected valid=1 data=%h",
                             o_RX_VALID, o_RX_DATA, w);
                end
            end
            step(2'b00, 2'b00, w[15-i], 1'b0);
            step(2'b10, 2'b00, 1'b0, 1'b0);
            step(2'b00, 2'b00, 1'b0, 1'b0);
        end
    endtask

    task automatic ack();
        step(2'b00, {i_CS_Q[0], i_CS_Q[0]}, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        i_RST = 1'b1;
        i_SCK_Q = 2'b00; i_CS_Q = 2'b11; i_MOSI = 1'b0; i_RX_ACK = 1'b0; i_TX_DATA = 16'h0000;
        repeat (3) @(posedge i_CLK);
        #1;
        checks++;
        if ({o_RX_DATA, o_RX_VALID, o_MISO, o_BUSY, o_OVERRUN} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h v=%b miso=%b busy=%b ovr=%b expected all 0",
                     o_RX_DATA, o_RX_VALID, o_MISO, o_BUSY, o_OVERRUN);
        end
        @(negedge i_CLK);
        i_RST = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] m;
        i_TX_DATA = 16'h3C5A;
        // SCK activity in IDLE must not move the bit counter.
        for (int i = 0; i < 5; i++) begin
            step(2'b01, 2'b11, 1'b1, 1'b0);
            step(2'b10, 2'b11, 1'b1, 1'b0);
        end
        checks++;
        if (o_BUSY !== 1'b0 || o_MISO !== 1'b0) begin
            errors++;
            $display("FAIL idle_sck: got busy=%b miso=%b expected 0 0", o_BUSY, o_MISO);
        end
        step(2'b00, 2'b10, 1'b0, 1'b0);
        checks++;
        if (o_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_cs_fall: got %b expected 1", o_BUSY);
        end
        step(2'b00, 2'b00, 1'b0, 1'b0);
        send_bits(16'hA5C3, 16, 1'b0, 1'b0, m);
        checks++;
        if (m !== 16'h3C5A) begin
            errors++;
            $display("FAIL basic_miso: got %h expected 3c5a", m);
        end
        ack();
        checks++;
        if (o_RX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL ack_clears: got %b expected 0", o_RX_VALID);
        end
        ack();
        checks++;
        if (o_RX_VALID !== 1'b0 || o_RX_DATA !== 16'hA5C3) begin
            errors++;
            $display("FAIL ack_when_idle: got v=%b data=%h expected 0 a5c3", o_RX_VALID, o_RX_DATA);
        end
        cs_rise();
        checks++;
        if (o_BUSY !== 1'b0 || o_MISO !== 1'b0) begin
            errors++;
            $display("FAIL cs_rise_idle: got busy=%b miso=%b expected 0 0", o_BUSY, o_MISO);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] m;
        i_TX_DATA = 16'hCAFE;
        cs_fall();
        i_TX_DATA = 16'h0F0F;
        send_bits(16'h1234, 16, 1'b0, 1'b0, m);
        checks++;
        if (m !== 16'hCAFE) begin
            errors++;
            $display("FAIL b2b_miso1: got %h expected cafe", m);
        end
        ack();
        send_bits(16'hBEEF, 16, 1'b0, 1'b0, m);
        checks++;
        if (m !== 16'h0F0F) begin
            errors++;
            $display("FAIL b2b_miso2: got %h expected 0f0f", m);
        end
        ack();
        cs_rise();
    endtask

    task automatic test_abort();
        logic [15:0] m;
        cs_fall();
        send_bits(16'hFFFF, 7, 1'b0, 1'b0, m);
        cs_rise();
        checks++;
        if (o_RX_VALID !== 1'b0 || o_RX_DATA !== 16'hBEEF || o_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL abort: got v=%b data=%h busy=%b expected 0 beef 0", o_RX_VALID, o_RX_DATA, o_BUSY);
        end
        cs_fall();
        send_bits(16'h00FF, 16, 1'b0, 1'b0, m);
        ack();
        cs_rise();
    endtask

    task automatic test_overrun();
        logic [15:0] m;
        cs_fall();
        send_bits(16'h1111, 16, 1'b0, 1'b0, m);
        send_bits(16'h2222, 16, 1'b1, 1'b0, m);
        checks++;
        if (o_OVERRUN !== OVR_EXP || o_RX_DATA !== 16'h2222) begin
            errors++;
            $display("FAIL overrun: got ovr=%b data=%h expected ovr=%b data=2222", o_OVERRUN, o_RX_DATA, OVR_EXP);
        end
        ack();
        checks++;
        if (o_OVERRUN !== OVR_EXP) begin
            errors++;
            $display("FAIL overrun_sticky: got %b expected %b", o_OVERRUN, OVR_EXP);
        end
        cs_rise();
    endtask

    task automatic test_reset_mid();
        logic [15:0] m;
        i_TX_DATA = 16'hFFFF;
        cs_fall();
        send_bits(16'hFFFF, 9, 1'b0, 1'b0, m);
        @(negedge i_CLK);
        i_RST = 1'b1;
        #1;
        checks++;
        if ({o_RX_DATA, o_RX_VALID, o_MISO, o_BUSY, o_OVERRUN} !== 20'h0) begin
            errors++;
            $display("FAIL reset_mid: got data=%h v=%b miso=%b busy=%b ovr=%b expected all 0",
                     o_RX_DATA, o_RX_VALID, o_MISO, o_BUSY, o_OVERRUN);
        end
        @(negedge i_CLK);
        i_RST = 1'b0;
        // CS still low after reset: SCK must be ignored until a fresh CS fall.
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 2'b00, 1'b1, 1'b0);
            step(2'b10, 2'b00, 1'b1, 1'b0);
        end
        checks++;
        if (o_BUSY !== 1'b0 || o_RX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_wait: got busy=%b v=%b expected 0 0", o_BUSY, o_RX_VALID);
        end
        cs_rise();
        cs_fall();
        send_bits(16'h8001, 16, 1'b0, 1'b0, m);
    endtask

    task automatic test_ack_same_cycle();
        logic [15:0] m;
        send_bits(16'h5A5A, 16, 1'b1, 1'b1, m);
        checks++;
        if (o_OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL ack_same_cycle_ovr: got %b expected 0", o_OVERRUN);
        end
        ack();
    endtask

    task automatic test_cs_priority();
        logic [15:0] m;
        send_bits(16'hFFFF, 15, 1'b0, 1'b0, m);
        step(2'b01, 2'b01, 1'b1, 1'b0);
        checks++;
        if (o_RX_VALID !== 1'b0 || o_RX_DATA !== 16'h5A5A || o_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL cs_priority: got v=%b data=%h busy=%b expected 0 5a5a 0", o_RX_VALID, o_RX_DATA, o_BUSY);
        end
        step(2'b00, 2'b11, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_overrun();
        test_reset_mid();
        test_ack_same_cycle();
        test_cs_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx_core.md
SPI_SLAVE_RX_CORE -- requirements
Module: spi_slave_rx_core

Interface
REQ-001 Parameter DATA_WIDTH, default 16: bits per SPI word (legal 2..32).
REQ-002 i_CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 i_RST  input  1  asynchronous, active-high reset.
REQ-004 i_SCK_Q  input  2  synchronized SCK history from upstream buffer; [1] older sample, [0] newer sample.
REQ-005 i_CS_Q  input  2  synchronized active-low chip select history; [1] older, [0] newer.
REQ-006 i_MOSI  input  1  synchronized MOSI bit, aligned with i_SCK_Q[0].
REQ-007 i_TX_DATA  input  DATA_WIDTH  word to return on MISO.
REQ-008 i_RX_ACK  input  1  consumer acknowledge; clears o_RX_VALID.
REQ-009 o_RX_DATA  output  DATA_WIDTH  last complete received word, MSB first on the wire.
REQ-010 o_RX_VALID  output  1  high while o_RX_DATA holds an unacknowledged word.
REQ-011 o_MISO  output  1  serial output, MSB first.
REQ-012 o_BUSY  output  1  high while state is SHIFT.
REQ-013 o_OVERRUN  output  1  sticky overrun flag (see Configuration).

Function
REQ-014 SPI mode 0 only: SCK rise = i_SCK_Q==2'b01, SCK fall = i_SCK_Q==2'b10; CS fall = i_CS_Q==2'b10, CS rise = i_CS_Q==2'b01.
REQ-015 States IDLE and SHIFT; IDLE->SHIFT on CS fall; SHIFT->IDLE on CS rise; no other transitions.
REQ-016 On IDLE->SHIFT: bit counter = 0, RX shift register = 0, TX shift register loaded from i_TX_DATA, so o_MISO = i_TX_DATA[DATA_WIDTH-1] the following cycle.
REQ-017 In SHIFT, on SCK rise: RX shift register shifts left, i_MOSI into LSB; bit counter increments.
REQ-018 In SHIFT, on SCK fall: TX shift register shifts left, 0 into LSB, unless the word just completed.
REQ-019 Word completion: SCK rise with bit counter == DATA_WIDTH-1; next cycle o_RX_DATA = full received word and o_RX_VALID = 1 (one-cycle latency from the completing edge).
REQ-020 On completion, bit counter wraps to 0 and TX shift register reloads from i_TX_DATA on the next SCK fall, supporting back-to-back words within one CS assertion.
REQ-021 o_RX_VALID clears the cycle after i_RX_ACK=1; i_RX_ACK while o_RX_VALID=0 has no effect.
REQ-022 Simultaneous completion and i_RX_ACK: new word is latched, o_RX_VALID stays 1.
REQ-023 CS rise mid-word: partial word discarded, o_RX_DATA/o_RX_VALID unchanged, counter cleared.
REQ-024 SCK edges while in IDLE are ignored; o_MISO = 0 in IDLE.
REQ-025 Simultaneous SCK and CS edges in one cycle: the CS edge takes priority, and the SCK edge is ignored.

Reset
REQ-026 While i_RST=1: state = IDLE; counter, shift registers, o_RX_DATA = 0; o_RX_VALID, o_MISO, o_BUSY, o_OVERRUN = 0.
REQ-027 Reset mid-transfer abandons the word; after release, the block waits for a fresh CS fall before shifting.

Configuration
REQ-028 Macro SPI_SLAVE_OVERRUN_EN defined: o_OVERRUN set the cycle after a completion occurs while o_RX_VALID=1 and i_RX_ACK=0; the new word still overwrites o_RX_DATA; the flag clears only on reset.
REQ-029 Macro SPI_SLAVE_OVERRUN_EN undefined: o_OVERRUN tied to 0, no overrun logic; overwrite behaviour is unchanged.

Verification
REQ-030 DATA_WIDTH=16, CS low, 16 SCK cycles MOSI=0xA5C3, i_TX_DATA=0x3C5A -> o_RX_DATA=0xA5C3, o_RX_VALID=1 one cycle after the 16th rise, MISO bits = 0x3C5A.
REQ-031 Two back-to-back words 0x1234, 0xBEEF in one CS, ACK after each -> two valid events, data matches, counter wraps cleanly.
REQ-032 CS rises after 7 bits -> no valid pulse; next full word 0x00FF received correctly.
REQ-033 Second word completes with first unacked (macro defined) -> o_OVERRUN=1 and o_RX_DATA=second word; with the macro undefined -> o_OVERRUN=0.
REQ-034 i_RST pulsed after bit 9 -> all outputs 0; new CS frame with 0x8001 -> received exactly.
REQ-035 i_RX_ACK asserted in the same cycle as completion -> o_RX_VALID remains 1 with the new data.
